// File: rtl/wb_pic_lite.sv
// rtl/wb_pic_lite.sv - edge-triggered fixed-priority interrupt controller with a Wishbone classic register slave.
// Optional build macro AUTO_EOI_EN: interrupt_done retires the vector without setting ISR; EOI becomes a no-op.
module wb_pic_lite #(
   parameter int NIRQ = 8,
   parameter int DW   = 32
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_n_i,
   input  logic [NIRQ-1:0] irq_i,
   input  logic [3:0]      wbs_adr_i,
   input  logic [DW-1:0]   wbs_dat_i,
   input  logic [DW/8-1:0] wbs_sel_i,
   input  logic            wbs_we_i,
   input  logic            wbs_cyc_i,
   input  logic            wbs_stb_i,
   output logic [DW-1:0]   wbs_dat_o,
   output logic            wbs_ack_o,
   output logic            interrupt_do,
   output logic [7:0]      interrupt_vector,
   input  logic            interrupt_done
);

   localparam logic [7:0] LINE_MASK = 8'((16'd1 << NIRQ) - 16'd1);

   localparam logic [1:0] REG_BASE = 2'd0;
   localparam logic [1:0] REG_IMR  = 2'd1;
   localparam logic [1:0] REG_STAT = 2'd2;
   localparam logic [1:0] REG_EOI  = 2'd3;

   typedef enum logic {ST_IDLE, ST_REQ} state_t;

   state_t          state_q, state_d;
   logic [NIRQ-1:0] sync1_q, sync2_q, edge_q;
   logic [7:0]      irr_q, irr_d;
   logic [7:0]      isr_q, isr_d;
   logic [7:0]      imr_q, imr_d;
   logic [4:0]      base_q, base_d;
   logic            ack_q, ack_d;
   logic [DW-1:0]   dat_q, dat_d;
   logic            do_q, do_d;
   logic [7:0]      vec_q, vec_d;
   logic [2:0]      num_q, num_d;

   logic [7:0]      rise;
   logic [7:0]      pend;
   logic [7:0]      eoi_clr;
   logic [7:0]      done_set;
   logic            wb_req, wb_wr, eoi_wr;
   logic            win_found, blocked;
   logic [2:0]      win_n;

   logic unused_bits;
   assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[DW-1:8], wbs_sel_i[DW/8-1:1]};

   assign wbs_dat_o        = dat_q;
   assign wbs_ack_o        = ack_q;
   assign interrupt_do     = do_q;
   assign interrupt_vector = vec_q;

   always_comb begin
      rise = '0;
      rise[NIRQ-1:0] = sync2_q & ~edge_q;

      wb_req = wbs_cyc_i & wbs_stb_i & ~ack_q;
      wb_wr  = wb_req & wbs_we_i & wbs_sel_i[0];
      eoi_wr = wb_wr & (wbs_adr_i[3:2] == REG_EOI);

      // Lowest pending unmasked line wins; any in-service line of equal or higher priority blocks it.
      pend      = irr_q & ~imr_q;
      win_found = 1'b0;
      win_n     = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (pend[i]) begin
            win_found = 1'b1;
            win_n     = 3'(i);
         end
      end
      blocked = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (isr_q[i] && (i <= int'(win_n))) blocked = 1'b1;
      end

      eoi_clr = '0;
      for (int i = 7; i >= 0; i--) begin
         if (isr_q[i]) begin
            eoi_clr    = '0;
            eoi_clr[i] = 1'b1;
         end
      end

      state_d  = state_q;
      do_d     = do_q;
      vec_d    = vec_q;
      num_d    = num_q;
      done_set = '0;
      case (state_q)
         ST_IDLE: begin
            if (win_found && !blocked) begin
               state_d = ST_REQ;
               do_d    = 1'b1;
               vec_d   = {base_q, win_n};
               num_d   = win_n;
            end
         end
         ST_REQ: begin
            if (interrupt_done) begin
               state_d         = ST_IDLE;
               do_d            = 1'b0;
               done_set[num_q] = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A fresh edge in the retire cycle re-arms the line.
      irr_d = (irr_q & ~done_set) | rise;
`ifdef AUTO_EOI_EN
      isr_d = '0;
`else
      isr_d = (isr_q & ~(eoi_wr ? eoi_clr : 8'h00)) | done_set;
`endif

      base_d = base_q;
      imr_d  = imr_q;
      if (wb_wr) begin
         case (wbs_adr_i[3:2])
            REG_BASE: base_d = wbs_dat_i[7:3];
            REG_IMR:  imr_d  = wbs_dat_i[7:0] & LINE_MASK;
            default:  ;
         endcase
      end

      ack_d = wb_req;
      dat_d = '0;
      if (wb_req && !wbs_we_i) begin
         case (wbs_adr_i[3:2])
            REG_BASE: dat_d = DW'({base_q, 3'b000});
            REG_IMR:  dat_d = DW'(imr_q);
            REG_STAT: dat_d = DW'({do_q, isr_q, irr_q});
            default:  dat_d = '0;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state_q <= ST_IDLE;
         sync1_q <= '0;
         sync2_q <= '0;
         edge_q  <= '0;
         irr_q   <= '0;
         isr_q   <= '0;
         imr_q   <= LINE_MASK;
         base_q  <= 5'd1;
         ack_q   <= 1'b0;
         dat_q   <= '0;
         do_q    <= 1'b0;
         vec_q   <= '0;
         num_q   <= '0;
      end else begin
         state_q <= state_d;
         sync1_q <= irq_i;
         sync2_q <= sync1_q;
         edge_q  <= sync2_q;
         irr_q   <= irr_d;
         isr_q   <= isr_d;
         imr_q   <= imr_d;
         base_q  <= base_d;
         ack_q   <= ack_d;
         dat_q   <= dat_d;
         do_q    <= do_d;
         vec_q   <= vec_d;
         num_q   <= num_d;
      end
   end

endmodule

// File: tb/tb_wb_pic_lite.sv
// tb/tb_wb_pic_lite.sv - directed self-checking bench for wb_pic_lite.
// Expectations follow AUTO_EOI_EN the same way the design does.
module tb_wb_pic_lite;

`ifdef AUTO_EOI_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  irq;
   logic [3:0]  adr;
   logic [31:0] wdat;
   logic [3:0]  sel;
   logic        we, cyc, stb;
   logic [31:0] rdat;
   logic        ack;
   logic        int_do;
   logic [7:0]  int_vec;
   logic        int_done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   wb_pic_lite #(.NIRQ(8), .DW(32)) dut (
      .wb_clk_i         (clk),
      .wb_rst_n_i       (rst_n),
      .irq_i            (irq),
      .wbs_adr_i        (adr),
      .wbs_dat_i        (wdat),
      .wbs_sel_i        (sel),
      .wbs_we_i         (we),
      .wbs_cyc_i        (cyc),
      .wbs_stb_i        (stb),
      .wbs_dat_o        (rdat),
      .wbs_ack_o        (ack),
      .interrupt_do     (int_do),
      .interrupt_vector (int_vec),
      .interrupt_done   (int_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_xfer(input logic wr, input logic [3:0] a, input logic [31:0] d,
                          output logic [31:0] q);
      int n;
      tick();
      cyc = 1'b1; stb = 1'b1; we = wr; adr = a; wdat = d; sel = 4'h1;
      n = 0;
      q = '0;
      do begin
         tick();
         n++;
      end while (!ack && n < 10);
      q = rdat;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      check("wb_ack_latency", 32'(n), 32'd1);
   endtask

   task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
      logic [31:0] q;
      wb_xfer(1'b1, a, d, q);
   endtask

   task automatic wb_read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] q;
      wb_xfer(1'b0, a, 32'h0, q);
      check(tag, q, exp);
   endtask

   task automatic pulse_irq(input int n);
      tick();
      irq[n] = 1'b1;
      tick();
      irq[n] = 1'b0;
   endtask

   task automatic pulse_done();
      tick();
      int_done = 1'b1;
      tick();
      int_done = 1'b0;
   endtask

   task automatic wait_do(input string tag);
      int n;
      n = 0;
      while (!int_do && n < 20) begin
         tick();
         n++;
      end
      check(tag, 32'(int_do), 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int lat;
      rst_n = 1'b0; irq = '0; adr = '0; wdat = '0; sel = '0;
      we = 1'b0; cyc = 1'b0; stb = 1'b0; int_done = 1'b0;
      idle(3);
      rst_n = 1'b1;

      // 1: reset values
      check("rst_do", 32'(int_do), 32'd0);
      check("rst_vec", 32'(int_vec), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      wb_read_check("rst_imr", 4'h4, 32'h0000_00FF);
      wb_read_check("rst_base", 4'h0, 32'h0000_0008);
      wb_read_check("rst_stat", 4'h8, 32'h0000_0000);
      wb_read_check("eoi_reads_zero", 4'hC, 32'h0000_0000);
      pulse_done();
      check("done_idle_ignored", 32'(int_do), 32'd0);

      // 2: single request on irq 0, exact latency
      wb_write(4'h4, 32'h0000_00FE);
      tick();
      irq[0] = 1'b1;
      tick();
      irq[0] = 1'b0;
      lat = 1;
      while (!int_do && lat < 10) begin
         tick();
         lat++;
      end
      check("t2_latency", 32'(lat), 32'd4);
      check("t2_vec", 32'(int_vec), 32'h08);
      pulse_done();
      check("t2_do_drop", 32'(int_do), 32'd0);
      wb_read_check("t2_stat", 4'h8, AUTO ? 32'h0 : 32'h0000_0100);

      // 3: simultaneous edges on 5 and 2, priority order
      wb_write(4'hC, 32'h1);
      wb_write(4'h4, 32'h0);
      wb_write(4'h0, 32'h0000_0020);
      wb_read_check("t3_base", 4'h0, 32'h0000_0020);
      tick();
      irq[5] = 1'b1; irq[2] = 1'b1;
      tick();
      irq[5] = 1'b0; irq[2] = 1'b0;
      wait_do("t3_do_a");
      check("t3_vec_a", 32'(int_vec), 32'h22);
      pulse_done();
      wb_write(4'hC, 32'h1);
      wait_do("t3_do_b");
      check("t3_vec_b", 32'(int_vec), 32'h25);
      pulse_done();
      wb_write(4'hC, 32'h1);
      idle(2);
      wb_read_check("t3_stat", 4'h8, 32'h0);

`ifndef AUTO_EOI_EN
      // 4: in-service line 3 blocks 6 but not 1
      pulse_irq(3);
      wait_do("t4_do3");
      check("t4_vec3", 32'(int_vec), 32'h23);
      pulse_done();
      pulse_irq(6);
      idle(8);
      check("t4_irq6_blocked", 32'(int_do), 32'd0);
      pulse_irq(1);
      wait_do("t4_do1");
      check("t4_vec1", 32'(int_vec), 32'h21);
      pulse_done();
      wb_read_check("t4_stat_a", 4'h8, 32'h0000_0A40);
      wb_write(4'hC, 32'h1);
      idle(4);
      wb_read_check("t4_stat_b", 4'h8, 32'h0000_0840);
      wb_write(4'hC, 32'h1);
      wait_do("t4_do6");
      check("t4_vec6", 32'(int_vec), 32'h26);
      pulse_done();
      wb_write(4'hC, 32'h1);
      idle(2);
      wb_read_check("t4_stat_c", 4'h8, 32'h0);
`endif

      // 5: IMR write during REQ, re-arm edge in the done cycle
      pulse_irq(4);
      wait_do("t5_do");
      check("t5_vec", 32'(int_vec), 32'h24);
      wb_write(4'h4, 32'h0000_00FF);
      idle(2);
      check("t5_do_held", 32'(int_do), 32'd1);
      check("t5_vec_held", 32'(int_vec), 32'h24);
      tick();
      irq[4] = 1'b1;
      tick();
      irq[4] = 1'b0;
      tick();
      int_done = 1'b1;
      tick();
      int_done = 1'b0;
      check("t5_do_drop", 32'(int_do), 32'd0);
      wb_read_check("t5_stat", 4'h8, AUTO ? 32'h0000_0010 : 32'h0000_1010);

      // 6: reset while in REQ
      wb_write(4'h4, 32'h0000_00EF);
      wb_write(4'hC, 32'h1);
      wait_do("t6_do");
      check("t6_vec", 32'(int_vec), 32'h24);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t6_do_rst", 32'(int_do), 32'd0);
      check("t6_vec_rst", 32'(int_vec), 32'd0);
      wb_read_check("t6_stat", 4'h8, 32'h0);
      wb_read_check("t6_imr", 4'h4, 32'h0000_00FF);
      wb_read_check("t6_base", 4'h0, 32'h0000_0008);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
